// File: rtl/adc_emu_pkg.sv
// adc_emu_pkg: shared command-field positions and FSM encoding for the SPI ADC emulator
package adc_emu_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} state_e;
  function automatic int cmd_valid_bit(input int data_w);
    return data_w - 1;
  endfunction
  function automatic int cmd_ch_msb(input int data_w);
    return data_w - 2;
  endfunction
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-stage synchroniser with one-cycle rise/fall pulses on the synced level
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);
  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end
  assign rise_o = sync_q[STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[STAGES-1] & prev_q;
endmodule

// File: rtl/spi_adc_emulator.sv
// spi_adc_emulator: SPI mode-0 ADC peripheral streaming per-channel sample tables, one frame per transfer
module spi_adc_emulator
  import adc_emu_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int NUM_CH      = 2,
  parameter int DEPTH       = 1000,
  parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter bit OFFSET_BIN  = 1'b1,
  parameter int SYNC_STAGES = 2,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              sck_i,
  input  logic              cs_ni,
  input  logic              sdi_i,
  output logic              sdo_o,
  input  logic              ld_en_i,
  input  logic [CH_W-1:0]   ld_ch_i,
  input  logic [AW-1:0]     ld_addr_i,
  input  logic [DATA_W-1:0] ld_data_i,
  output logic              frame_done_o,
  output logic [DATA_W-1:0] last_cmd_o
);
  localparam int MW            = $clog2(NUM_CH * DEPTH);
  localparam int CW            = $clog2(DATA_W);
  localparam int CMD_VALID_BIT = cmd_valid_bit(DATA_W);
  localparam int CMD_CH_MSB    = cmd_ch_msb(DATA_W);

  state_e              state_q, state_d;
  logic                sck_rise, sck_fall, cs_rise, cs_fall;
  logic                enter, act, rise_ev, fall_ev, done, dec_ok, wr_ok;
  logic [SYNC_STAGES-1:0] sdi_q;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DATA_W-2:0]   cmd_q, cmd_d;
  logic [DATA_W-1:0]   cmd_full, sh_q, sh_d, last_q, last_d, rd_q, next_data;
  logic                sdo_q, sdo_d, done_q, nv_q, nv_d, pv_q, pv_d;
  logic [CH_W-1:0]     pch_q, pch_d, dec_ch;
  logic [AW-1:0]       ptr_q [NUM_CH];
  logic [AW-1:0]       ptr_d [NUM_CH];
  logic [MW-1:0]       rd_addr, wr_addr;
  logic [DATA_W-1:0]   mem [NUM_CH*DEPTH];

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
    .clk_i(clk_i), .rst_ni(rst_ni), .d_i(sck_i), .rise_o(sck_rise), .fall_o(sck_fall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk_i(clk_i), .rst_ni(rst_ni), .d_i(cs_ni), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = (state_q == ST_IDLE && cs_fall)   ? ST_ACTIVE :
              (state_q == ST_ACTIVE && cs_rise) ? ST_IDLE   : state_q;
  end

  always_comb begin
    enter   = (state_q == ST_IDLE) && cs_fall;
    act     = (state_q == ST_ACTIVE) && !cs_rise;
    rise_ev = act && sck_rise;
    fall_ev = act && sck_fall;
    done    = rise_ev && (cnt_q == CW'(DATA_W - 1));
  end

  // SDI chain matches the SCK synchroniser depth so the captured bit lines up with the rise pulse
  always_comb begin
    cmd_full  = {cmd_q, sdi_q[SYNC_STAGES-1]};
    dec_ch    = cmd_full[CMD_CH_MSB -: CH_W];
    dec_ok    = cmd_full[CMD_VALID_BIT] && (32'(dec_ch) < NUM_CH);
    next_data = nv_q ? {rd_q[DATA_W-1] ^ OFFSET_BIN, rd_q[DATA_W-2:0]} : '0;
    ptr_d     = ptr_q;
    if (done && pv_q)
      ptr_d[pch_q] = (32'(ptr_q[pch_q]) == DEPTH - 1) ? '0 : ptr_q[pch_q] + 1'b1;
    rd_addr   = MW'(32'(dec_ch) * DEPTH + 32'(ptr_d[dec_ch]));
    wr_ok     = ld_en_i && (32'(ld_addr_i) < DEPTH) && (32'(ld_ch_i) < NUM_CH);
    wr_addr   = MW'(32'(ld_ch_i) * DEPTH + 32'(ld_addr_i));
    cnt_d     = (!act || done) ? '0 : rise_ev ? cnt_q + 1'b1 : cnt_q;
    cmd_d     = rise_ev ? cmd_full[DATA_W-2:0] : cmd_q;
    // the fall that follows the last rise of a frame reloads rather than shifts
    sh_d      = (enter || (fall_ev && cnt_q == '0)) ? next_data : fall_ev ? sh_q << 1 : sh_q;
    sdo_d     = act && sh_q[DATA_W-1];
    last_d    = done ? cmd_full : last_q;
    nv_d      = done ? dec_ok : nv_q;
    pv_d      = done ? dec_ok : pv_q;
    pch_d     = done ? dec_ch : pch_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sdi_q  <= '0;
      cnt_q  <= '0;
      cmd_q  <= '0;
      sh_q   <= '0;
      sdo_q  <= 1'b0;
      done_q <= 1'b0;
      last_q <= '0;
      nv_q   <= 1'b0;
      pv_q   <= 1'b0;
      pch_q  <= '0;
      for (int c = 0; c < NUM_CH; c++) ptr_q[c] <= '0;
    end else begin
      sdi_q  <= {sdi_q[SYNC_STAGES-2:0], sdi_i};
      cnt_q  <= cnt_d;
      cmd_q  <= cmd_d;
      sh_q   <= sh_d;
      sdo_q  <= sdo_d;
      done_q <= done;
      last_q <= last_d;
      nv_q   <= nv_d;
      pv_q   <= pv_d;
      pch_q  <= pch_d;
      ptr_q  <= ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_ok) mem[wr_addr] <= ld_data_i;
    if (done)  rd_q <= mem[rd_addr];
  end

  assign sdo_o        = sdo_q;
  assign frame_done_o = done_q;
  assign last_cmd_o   = last_q;
endmodule
